// File: rtl/data_memory_unit.sv
// Word-organised data memory with byte/half/word loads and stores, 1-cycle load latency,
// and an optional post-reset clearing sweep that gates request acceptance.
module data_memory_unit #(
    parameter int ADDR_BITS  = 8,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        error,
    output logic        init_done
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {INIT, RUN} state_t;

    state_t               state, state_nx;
    logic [ADDR_BITS-1:0] clr_cnt, clr_cnt_nx;
    logic [3:0][7:0]      mem [DEPTH];

    logic [ADDR_BITS-1:0] idx;
    logic [1:0]           lane;
    logic                 illegal, accept, do_store, do_load;
    logic [3:0]           be;
    logic [31:0]          wdata_al, rd_word, rd_shift, load_val;

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        case (state)
            INIT: begin
                if (!INIT_CLEAR) begin
                    state_nx = RUN;
                end else begin
                    clr_cnt_nx = clr_cnt + 1'b1;
                    if (&clr_cnt) state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    assign init_done = (state == RUN);
    assign req_ready = init_done;

    assign idx  = address[ADDR_BITS+1:2];
    assign lane = address[1:0];

    // Any address bit above the memory's reach makes the access illegal.
    always_comb begin
        illegal = 1'b0;
        be      = 4'b0000;
        case (req_size)
            2'b00: be = 4'b0001 << lane;
            2'b01: begin
                be      = 4'b0011 << lane;
                illegal = address[0];
            end
            2'b10: begin
                be      = 4'b1111;
                illegal = |address[1:0];
            end
            default: illegal = 1'b1;
        endcase
        if ((address >> (ADDR_BITS + 2)) != 32'd0) illegal = 1'b1;
    end

    assign accept   = req_valid & req_ready;
    assign do_store = accept & req_write & ~illegal;
    assign do_load  = accept & ~req_write & ~illegal;
    assign wdata_al = write_data << {lane, 3'b000};

    // Storage has no reset: only the clearing sweep (never reset itself) zeroes it.
    always_ff @(posedge clock) begin
        if (reset_n && state == INIT && INIT_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (do_store) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem[idx][l] <= wdata_al[8*l +: 8];
            end
        end
    end

    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        case (req_size)
            2'b00:   load_val = {{24{~req_unsigned & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   load_val = {{16{~req_unsigned & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            clr_cnt    <= '0;
            read_valid <= 1'b0;
            error      <= 1'b0;
            read_data  <= '0;
        end else begin
            state      <= state_nx;
            clr_cnt    <= clr_cnt_nx;
            read_valid <= do_load;
            error      <= accept & illegal;
            if (do_load) read_data <= load_val;
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomised and directed bench for data_memory_unit against a byte-addressed reference memory.
module tb_data_memory_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] address = '0, write_data = '0;
    logic        req_ready, read_valid, error, init_done;
    logic [31:0] read_data;

    int nvec = 0, nfail = 0;

    logic [7:0]  mbytes [0:1023];
    logic [31:0] exp_rd = '0;
    logic        exp_vld = 1'b0, exp_err = 1'b0;

    data_memory_unit dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .write_data(write_data), .read_data(read_data),
        .read_valid(read_valid), .error(error), .init_done(init_done)
    );

    always #5 clock = ~clock;

    function automatic bit legal_f(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b0;
        if (a >= 32'd1024) return 1'b0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic logic [31:0] load_f(input logic [1:0] sz, input logic u, input logic [31:0] a);
        int n = 1 << sz;
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(mbytes[int'(a) + k]) << (8 * k));
        if (n < 4 && !u && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) mbytes[i] = 8'h00;
        exp_vld = 1'b0;
        exp_err = 1'b0;
    endtask

    // Counts edges from reset release until init_done; also notes any cycle where ready != init_done.
    task automatic wait_init(output int n, output int mism);
        n = 0;
        mism = 0;
        while (!init_done && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
            if (req_ready !== init_done) mism++;
        end
    endtask

    // Called at a negedge; applies one request cycle and checks the response one cycle later.
    task automatic step(input logic v, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
        req_valid = v; req_write = w; req_size = sz; req_unsigned = u;
        address = a; write_data = wd;
        @(posedge clock);
        exp_vld = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            if (!legal_f(sz, a)) exp_err = 1'b1;
            else if (w) begin
                for (int k = 0; k < (1 << sz); k++) mbytes[int'(a) + k] = wd[8*k +: 8];
            end else begin
                exp_vld = 1'b1;
                exp_rd  = load_f(sz, u, a);
            end
        end
        @(negedge clock);
        req_valid = 1'b0;
        nvec++;
        if (read_valid !== exp_vld) begin
            nfail++;
            $display("FAIL read_valid a=%h sz=%0d: got %b want %b", a, sz, read_valid, exp_vld);
        end
        nvec++;
        if (error !== exp_err) begin
            nfail++;
            $display("FAIL error a=%h sz=%0d: got %b want %b", a, sz, error, exp_err);
        end
        nvec++;
        if (read_data !== exp_rd) begin
            nfail++;
            $display("FAIL read_data a=%h sz=%0d: got %h want %h", a, sz, read_data, exp_rd);
        end
    endtask

    task automatic test_reset();
        #12;
        nvec++;
        if ({init_done, req_ready, read_valid, error} !== 4'b0000 || read_data !== 32'h0) begin
            nfail++;
            $display("FAIL reset_state: got done/rdy/vld/err=%b%b%b%b data=%h want 0000 00000000",
                     init_done, req_ready, read_valid, error, read_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_init();
        int n, mism;
        wait_init(n, mism);
        nvec++;
        if (n !== 256) begin
            nfail++;
            $display("FAIL init_cycles: got %0d want 256", n);
        end
        nvec++;
        if (mism !== 0 || req_ready !== 1'b1) begin
            nfail++;
            $display("FAIL ready_tracks_done: got %0d mismatches ready=%b want 0 ready=1", mism, req_ready);
        end
        clear_model();
        @(negedge clock);
        step(1, 0, 2'b10, 0, 32'h0000_00FC, 0);
        nvec++;
        if (read_data !== 32'h0) begin
            nfail++;
            $display("FAIL cleared_word_fc: got %h want 00000000", read_data);
        end
    endtask

    task automatic test_extend();
        logic [31:0] want [4];
        want = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_80FF, 32'h80FF_7F01};
        step(1, 1, 2'b10, 0, 32'h10, 32'h80FF_7F01);
        step(1, 0, 2'b00, 0, 32'h11, 0);
        nvec++;
        if (read_data !== want[0]) begin nfail++; $display("FAIL lb_lane1: got %h want %h", read_data, want[0]); end
        step(1, 0, 2'b00, 0, 32'h12, 0);
        nvec++;
        if (read_data !== want[1]) begin nfail++; $display("FAIL lb_lane2: got %h want %h", read_data, want[1]); end
        step(1, 0, 2'b01, 1, 32'h12, 0);
        nvec++;
        if (read_data !== want[2]) begin nfail++; $display("FAIL lhu_0x12: got %h want %h", read_data, want[2]); end
        step(1, 0, 2'b10, 1, 32'h10, 0);
        nvec++;
        if (read_data !== want[3]) begin nfail++; $display("FAIL lw_0x10: got %h want %h", read_data, want[3]); end
        step(1, 1, 2'b00, 0, 32'h13, 32'h0000_00AB);
        step(1, 0, 2'b10, 0, 32'h10, 0);
        nvec++;
        if (read_data !== 32'hABFF_7F01) begin
            nfail++;
            $display("FAIL sb_merge: got %h want abff7f01", read_data);
        end
    endtask

    task automatic test_illegal();
        step(1, 0, 2'b10, 0, 32'h0000_0002, 0);
        step(1, 1, 2'b01, 0, 32'h0000_0001, 32'h0000_5555);
        step(1, 1, 2'b11, 0, 32'h0000_0010, 32'h1234_5678);
        step(1, 1, 2'b10, 0, 32'h0000_0400, 32'hDEAD_BEEF);
        step(1, 0, 2'b10, 0, 32'h0000_0000, 0);
        step(1, 0, 2'b10, 0, 32'h0000_0010, 0);
        nvec++;
        if (read_data !== 32'hABFF_7F01) begin
            nfail++;
            $display("FAIL illegal_no_write: got %h want abff7f01", read_data);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 1, 2'b00, 0, 32'h20, 32'h0000_0011);
        step(1, 0, 2'b10, 0, 32'h20, 0);
        nvec++;
        if (read_valid !== 1'b1 || read_data !== 32'h11) begin
            nfail++;
            $display("FAIL b2b_first: got vld=%b %h want vld=1 00000011", read_valid, read_data);
        end
        step(1, 0, 2'b10, 0, 32'h24, 0);
        nvec++;
        if (read_valid !== 1'b1 || read_data !== 32'h0) begin
            nfail++;
            $display("FAIL b2b_second: got vld=%b %h want vld=1 00000000", read_valid, read_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic        v, w, u;
            logic [1:0]  sz;
            logic [31:0] a;
            v  = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
            if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(10, 31));
            step(v, w, sz, u, a, $urandom);
        end
    endtask

    task automatic test_reset_mid_init();
        int n, mism;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (100) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        nvec++;
        if ({init_done, req_ready, read_valid, error} !== 4'b0000 || read_data !== 32'h0) begin
            nfail++;
            $display("FAIL reset_mid_init: got done/rdy/vld/err=%b%b%b%b data=%h want 0000 00000000",
                     init_done, req_ready, read_valid, error, read_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
        wait_init(n, mism);
        nvec++;
        if (n !== 256 || mism !== 0) begin
            nfail++;
            $display("FAIL reinit_cycles: got %0d (mism %0d) want 256 (0)", n, mism);
        end
        clear_model();
        @(negedge clock);
        step(1, 0, 2'b10, 0, 32'h0000_0020, 0);
    endtask

    task automatic test_reset_mid_run();
        int n, mism;
        step(1, 1, 2'b10, 0, 32'h40, 32'hCAFE_F00D);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; address = 32'h40;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        nvec++;
        if (read_valid !== 1'b0 || read_data !== 32'h0 || init_done !== 1'b0) begin
            nfail++;
            $display("FAIL reset_aborts_load: got vld=%b data=%h done=%b want 0 00000000 0",
                     read_valid, read_data, init_done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        wait_init(n, mism);
        nvec++;
        if (n !== 256) begin
            nfail++;
            $display("FAIL run_reinit_cycles: got %0d want 256", n);
        end
        clear_model();
        @(negedge clock);
        step(1, 0, 2'b10, 0, 32'h40, 0);
    endtask

    initial begin
        clear_model();
        test_reset();
        test_init();
        test_extend();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_init();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
